// File: rtl/issue_scoreboard_if.sv
// Decode-to-scoreboard issue bus.
//   master : decode stage; drives the decoded instruction and flush, observes the decision.
//   slave  : issue_scoreboard; observes the instruction, drives in_ready/issue/stall.
// Signals:
//   in_valid, in_rs_en, in_rs[6:0], in_rt_en, in_rt[6:0], in_rw[1:0], in_rd[5:0],
//   in_wait[4:0], in_stop, flush       decode -> scoreboard
//   in_ready, issue, stall             scoreboard -> decode
interface issue_scoreboard_if;
    logic       in_valid;
    logic       in_rs_en;
    logic [6:0] in_rs;
    logic       in_rt_en;
    logic [6:0] in_rt;
    logic [1:0] in_rw;
    logic [5:0] in_rd;
    logic [4:0] in_wait;
    logic       in_stop;
    logic       flush;
    logic       in_ready;
    logic       issue;
    logic       stall;

    modport master (
        output in_valid, in_rs_en, in_rs, in_rt_en, in_rt, in_rw, in_rd, in_wait, in_stop, flush,
        input  in_ready, issue, stall
    );

    modport slave (
        input  in_valid, in_rs_en, in_rs, in_rt_en, in_rt, in_rw, in_rd, in_wait, in_stop, flush,
        output in_ready, issue, stall
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Register-scoreboard issue controller between decode and execute.
// Tracks, per architectural register (64 GPR + 64 FPR, tag = {is_fpr, index}), the number of
// cycles until its pending result reaches the forwarding bus, plus occupancy of the single
// iterative unit (divide / inverse / sqrt). Decides combinationally whether the decoded
// instruction may issue.
// Ports:
//   clk      clock, all state updates on posedge
//   rst      synchronous active-high reset
//   dec      issue bus (slave side): decoded instruction in, in_ready/issue/stall out
//   lu_done  iterative unit result is on the forwarding bus this cycle
//   halted   sticky, set once a stop instruction has issued
//   idle     no pending counters and iterative unit free
module issue_scoreboard (
    input  logic                  clk,
    input  logic                  rst,
    issue_scoreboard_if.slave     dec,
    input  logic                  lu_done,
    output logic                  halted,
    output logic                  idle
);

    localparam int unsigned NumRegs  = 128;
    localparam logic [4:0]  LongWait = 5'd31;

    logic [4:0] cnt_q [NumRegs];
    logic [4:0] cnt_d [NumRegs];
    logic       long_busy_q, long_busy_d;
    logic [6:0] long_tag_q, long_tag_d;
    logic       halted_q, halted_d;

    logic       has_dest;
    logic [6:0] dest_tag;
    logic       raw_ok, waw_ok, struct_ok;
    logic       ready;
    logic       is_long;
    logic       lu_clr;
    logic       pending;

    // Encoding 2'b11 of in_rw is treated as "no destination".
    assign has_dest = (dec.in_rw == 2'b01) || (dec.in_rw == 2'b10);
    assign dest_tag = {dec.in_rw == 2'b10, dec.in_rd};
    assign is_long  = (dec.in_wait == LongWait);

    assign raw_ok    = (!dec.in_rs_en || (cnt_q[dec.in_rs] == 5'd0)) &&
                       (!dec.in_rt_en || (cnt_q[dec.in_rt] == 5'd0));
    assign waw_ok    = !has_dest || (cnt_q[dest_tag] == 5'd0);
    // Uses the pre-edge busy flag, so a long op offered in the lu_done cycle waits one cycle.
    assign struct_ok = !is_long || !long_busy_q;

    assign ready = dec.in_valid && !rst && !halted_q && !dec.flush && raw_ok && waw_ok &&
                   struct_ok;

    assign dec.in_ready = ready;
    assign dec.issue    = dec.in_valid && ready;
    assign dec.stall    = dec.in_valid && !ready && !halted_q && !dec.flush;

    assign lu_clr = lu_done && long_busy_q;

    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            cnt_d[i] = cnt_q[i];
            // The long-op counter parks at 31 until lu_done clears it.
            if ((cnt_q[i] != 5'd0) &&
                !((cnt_q[i] == LongWait) && long_busy_q && (long_tag_q == 7'(i)))) begin
                cnt_d[i] = cnt_q[i] - 5'd1;
            end
            if (lu_clr && (long_tag_q == 7'(i))) begin
                cnt_d[i] = 5'd0;
            end
            // An issuing write to the same tag wins over the lu_done clear.
            if (ready && has_dest && (dec.in_wait != 5'd0) && (dest_tag == 7'(i))) begin
                cnt_d[i] = dec.in_wait;
            end
        end
    end

    always_comb begin
        long_busy_d = long_busy_q;
        long_tag_d  = long_tag_q;
        halted_d    = halted_q;
        if (lu_clr) begin
            long_busy_d = 1'b0;
        end
        if (ready && is_long) begin
            long_busy_d = 1'b1;
            if (has_dest) begin
                long_tag_d = dest_tag;
            end
        end
        if (ready && dec.in_stop) begin
            halted_d = 1'b1;
        end
    end

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < NumRegs; i++) begin
            pending = pending | (cnt_q[i] != 5'd0);
        end
    end

    assign idle   = !long_busy_q && !pending;
    assign halted = halted_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '{default: 5'd0};
            long_busy_q <= 1'b0;
            long_tag_q  <= 7'd0;
            halted_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            long_busy_q <= long_busy_d;
            long_tag_q  <= long_tag_d;
            halted_q    <= halted_d;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed vector table, hand-written multi-cycle
// sequences, then randomized stimulus against a timestamp-based reference model.
module tb_issue_scoreboard;

    logic clk;
    logic rst;
    logic lu_done;
    logic halted;
    logic idle;

    issue_scoreboard_if dec ();

    issue_scoreboard dut (
        .clk     (clk),
        .rst     (rst),
        .dec     (dec.slave),
        .lu_done (lu_done),
        .halted  (halted),
        .idle    (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       valid;
        logic       rs_en;
        logic [6:0] rs;
        logic [1:0] rw;
        logic [5:0] rd;
        logic [4:0] wt;
        logic       stop;
        logic       fl;
        logic       lu;
        logic       e_ready;
        logic       e_stall;
        logic       e_idle;
        logic       e_halted;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic se, logic [6:0] s, logic [1:0] rw, logic [5:0] rd,
                                logic [4:0] w, logic st, logic fl, logic lu,
                                logic er, logic es, logic ei, logic eh);
        vec_t r;
        r.valid = v; r.rs_en = se; r.rs = s; r.rw = rw; r.rd = rd; r.wt = w;
        r.stop = st; r.fl = fl; r.lu = lu;
        r.e_ready = er; r.e_stall = es; r.e_idle = ei; r.e_halted = eh;
        return r;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic se, input logic [6:0] s, input logic [1:0] rw,
                         input logic [5:0] rd, input logic [4:0] w, input logic st,
                         input logic fl, input logic lu);
        dec.in_valid = v;
        dec.in_rs_en = se;
        dec.in_rs    = s;
        dec.in_rt_en = 1'b0;
        dec.in_rt    = 7'd0;
        dec.in_rw    = rw;
        dec.in_rd    = rd;
        dec.in_wait  = w;
        dec.in_stop  = st;
        dec.flush    = fl;
        lu_done      = lu;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each register remembers the absolute cycle at which it becomes readable.
    localparam longint Inf = 64'h3fff_ffff_ffff_ffff;
    longint     ready_at [128];
    bit         m_long_busy;
    bit [6:0]   m_long_tag;
    bit         m_halted;
    longint     now;

    task automatic m_reset();
        for (int i = 0; i < 128; i++) ready_at[i] = 0;
        m_long_busy = 0;
        m_long_tag  = 0;
        m_halted    = 0;
    endtask

    function automatic bit m_has_dest();
        return (dec.in_rw == 2'b01) || (dec.in_rw == 2'b10);
    endfunction

    function automatic bit [6:0] m_dest();
        return {dec.in_rw == 2'b10, dec.in_rd};
    endfunction

    function automatic bit m_ready();
        if (rst || !dec.in_valid || m_halted || dec.flush) return 0;
        if (dec.in_rs_en && ready_at[dec.in_rs] > now) return 0;
        if (dec.in_rt_en && ready_at[dec.in_rt] > now) return 0;
        if (m_has_dest() && ready_at[m_dest()] > now) return 0;
        if (dec.in_wait == 5'd31 && m_long_busy) return 0;
        return 1;
    endfunction

    function automatic bit m_idle();
        if (m_long_busy) return 0;
        for (int i = 0; i < 128; i++) if (ready_at[i] > now) return 0;
        return 1;
    endfunction

    task automatic m_commit(input bit iss);
        if (rst) begin
            m_reset();
        end else begin
            if (lu_done && m_long_busy) begin
                m_long_busy = 0;
                if (ready_at[m_long_tag] > now + 1) ready_at[m_long_tag] = now + 1;
            end
            if (iss) begin
                if (dec.in_stop) m_halted = 1;
                if (dec.in_wait == 5'd31) begin
                    m_long_busy = 1;
                    if (m_has_dest()) begin
                        ready_at[m_dest()] = Inf;
                        m_long_tag = m_dest();
                    end
                end else if (m_has_dest() && dec.in_wait != 5'd0) begin
                    ready_at[m_dest()] = now + 1 + longint'(dec.in_wait);
                end
            end
        end
        now++;
    endtask

    function automatic logic [6:0] rnd_tag();
        return {1'($urandom % 2), 6'($urandom % 4)};
    endfunction

    initial begin
        bit er, es, ei;
        int r;

        // 2'b01 GPR, 2'b10 FPR
        vecs.push_back(mk(1, 0, 7'h00, 2'b01, 5, 0, 0, 0, 0, 1, 0, 1, 0));  // wait 0 dest
        vecs.push_back(mk(1, 0, 7'h00, 2'b01, 3, 3, 0, 0, 0, 1, 0, 1, 0));  // producer r3 w3
        vecs.push_back(mk(1, 1, 7'h03, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 7'h03, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 7'h03, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 7'h03, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 0));  // T+4 issues
        vecs.push_back(mk(1, 0, 7'h00, 2'b10, 7, 31, 0, 0, 0, 1, 0, 1, 0)); // long op f7
        vecs.push_back(mk(1, 1, 7'h47, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 7'h00, 2'b01, 9, 31, 0, 0, 0, 0, 1, 0, 0)); // structural
        vecs.push_back(mk(1, 0, 7'h00, 2'b01, 10, 4, 0, 0, 0, 1, 0, 0, 0)); // independent
        vecs.push_back(mk(1, 0, 7'h00, 2'b00, 0, 31, 0, 0, 1, 0, 1, 0, 0)); // long in lu cycle
        vecs.push_back(mk(1, 1, 7'h47, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 7'h00, 2'b00, 0, 31, 0, 0, 0, 1, 0, 0, 0)); // long, no dest
        vecs.push_back(mk(0, 0, 7'h00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 7'h00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 7'h00, 2'b01, 2, 5, 0, 0, 0, 1, 0, 1, 0));  // r2 w5
        vecs.push_back(mk(1, 0, 7'h00, 2'b01, 4, 2, 0, 1, 0, 0, 0, 0, 0));  // flushed
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 0, 7'h00, 2'b01, 2, 1, 0, 0, 0, 0, 1, 0, 0)); // WAW
        vecs.push_back(mk(1, 0, 7'h00, 2'b01, 2, 1, 0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 7'h00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 7'h00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 7'h00, 2'b01, 1, 3, 1, 0, 0, 1, 0, 1, 0));  // stop, r1 w3
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 0, 7'h00, 2'b01, 8, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 7'h00, 2'b01, 8, 0, 0, 0, 0, 0, 0, 1, 1));

        // Reset
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset in_ready", dec.in_ready, 1'b0);
        check("reset issue", dec.issue, 1'b0);
        check("reset stall", dec.stall, 1'b0);
        check("reset idle", idle, 1'b1);
        check("reset halted", halted, 1'b0);
        step();
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].rs_en, vecs[i].rs, vecs[i].rw, vecs[i].rd, vecs[i].wt,
                  vecs[i].stop, vecs[i].fl, vecs[i].lu);
            @(negedge clk);
            check($sformatf("vec%0d in_ready", i), dec.in_ready, vecs[i].e_ready);
            check($sformatf("vec%0d issue", i), dec.issue, vecs[i].e_ready);
            check($sformatf("vec%0d stall", i), dec.stall, vecs[i].e_stall);
            check($sformatf("vec%0d idle", i), idle, vecs[i].e_idle);
            check($sformatf("vec%0d halted", i), halted, vecs[i].e_halted);
            step();
        end

        // Reset clears the sticky halt
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        drive(1, 0, 7'h00, 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("post-reset halted", halted, 1'b0);
        check("post-reset issue", dec.issue, 1'b1);
        step();

        // Long op held 40 cycles without lu_done
        drive(1, 0, 7'h00, 2'b10, 7, 31, 0, 0, 0);
        @(negedge clk);
        check("long issue", dec.issue, 1'b1);
        step();
        for (int i = 0; i < 40; i++) begin
            drive(1, 1, 7'h47, 2'b00, 0, 0, 0, 0, 0);
            @(negedge clk);
            check($sformatf("long hold %0d stall", i), dec.stall, 1'b1);
            step();
        end
        drive(1, 1, 7'h47, 2'b00, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("long lu_done cycle stall", dec.stall, 1'b1);
        step();
        drive(1, 1, 7'h47, 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("long reader issue", dec.issue, 1'b1);
        check("long reader idle", idle, 1'b1);
        step();

        // Reset mid-operation overrides a ready instruction
        drive(1, 0, 7'h00, 2'b01, 20, 31, 0, 0, 0);
        step();
        drive(1, 0, 7'h00, 2'b01, 21, 20, 0, 0, 0);
        step();
        rst = 1'b1;
        drive(1, 0, 7'h00, 2'b01, 22, 3, 0, 0, 0);
        @(negedge clk);
        check("rst blocks in_ready", dec.in_ready, 1'b0);
        step();
        rst = 1'b0;
        dec.in_valid = 1'b0;
        @(negedge clk);
        check("mid-op reset idle", idle, 1'b1);
        drive(1, 1, 7'h14, 2'b01, 22, 0, 0, 0, 0);
        dec.in_rt_en = 1'b1;
        dec.in_rt    = 7'h15;
        @(negedge clk);
        check("mid-op reset reader", dec.issue, 1'b1);
        step();

        // Randomized run against the reference model
        m_reset();
        now = 0;
        for (int c = 0; c < 3000; c++) begin
            dec.in_valid = ($urandom % 4) != 0;
            dec.in_rs_en = $urandom % 2;
            dec.in_rs    = rnd_tag();
            dec.in_rt_en = $urandom % 2;
            dec.in_rt    = rnd_tag();
            dec.in_rw    = 2'($urandom % 4);
            dec.in_rd    = 6'($urandom % 4);
            r = int'($urandom % 16);
            if (r < 3)       dec.in_wait = 5'd0;
            else if (r < 5)  dec.in_wait = 5'd31;
            else if (r < 13) dec.in_wait = 5'($urandom_range(1, 6));
            else             dec.in_wait = 5'($urandom_range(7, 30));
            dec.in_stop = ($urandom % 300) == 0;
            dec.flush   = ($urandom % 8) == 0;
            lu_done     = ($urandom % 8) == 0;
            rst = (c == 0) || (($urandom % 400) == 0) || (m_halted && ($urandom % 20) == 0);
            @(negedge clk);
            er = m_ready();
            es = dec.in_valid && !er && !m_halted && !dec.flush;
            ei = m_idle();
            check($sformatf("rnd%0d in_ready", c), dec.in_ready, er);
            check($sformatf("rnd%0d issue", c), dec.issue, er);
            check($sformatf("rnd%0d stall", c), dec.stall, es);
            check($sformatf("rnd%0d idle", c), idle, ei);
            check($sformatf("rnd%0d halted", c), halted, m_halted);
            @(posedge clk);
            m_commit(er);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
